// File: rtl/tt_pad_ctrl_array.sv
// Runtime-configurable controller for NUM_CH bidirectional tile pads.
// A serial shadow chain is loaded into an active config that drives pad controls and the input filter.
module tt_pad_ctrl_array #(
    parameter int          NUM_CH   = 4,
    parameter int          FILT_LEN = 4,
    parameter logic [7:0]  RST_CFG  = 8'h24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_sdi,
    input  logic              cfg_shift,
    input  logic              cfg_load,
    output logic              cfg_sdo,
    input  logic [NUM_CH-1:0] dout,
    input  logic [NUM_CH-1:0] dout_oe,
    output logic [NUM_CH-1:0] din,
    input  logic [NUM_CH-1:0] pad_Y,
    output logic [NUM_CH-1:0] pad_A,
    output logic [NUM_CH-1:0] pad_OE,
    output logic [NUM_CH-1:0] pad_IE,
    output logic [NUM_CH-1:0] pad_SL,
    output logic [NUM_CH-1:0] pad_CS,
    output logic [NUM_CH-1:0] pad_PD,
    output logic [NUM_CH-1:0] pad_PU
);

    localparam int W  = 8 * NUM_CH;
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic [W-1:0]      r_shadow;
    logic [W-1:0]      r_active;
    logic [NUM_CH-1:0] r_s1;
    logic [NUM_CH-1:0] r_s2;
    logic [NUM_CH-1:0] r_din;
    logic [CW-1:0]     r_cnt [NUM_CH];

    logic [NUM_CH-1:0] r_pad_a, r_pad_oe, r_pad_ie, r_pad_sl, r_pad_cs, r_pad_pd, r_pad_pu;
    logic [NUM_CH-1:0] w_a, w_oe, w_ie, w_sl, w_cs, w_pd, w_pu;

    always_comb begin
        w_a  = '0;
        w_oe = '0;
        w_ie = '0;
        w_sl = '0;
        w_cs = '0;
        w_pd = '0;
        w_pu = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            case (r_active[8*k +: 2])
                2'b01: begin w_a[k] = dout[k]; w_oe[k] = 1'b1;       end
                2'b10: begin w_a[k] = dout[k]; w_oe[k] = dout_oe[k]; end
                2'b11: w_oe[k] = ~dout[k];
                default: ;
            endcase
            w_ie[k] = r_active[8*k + 2];
            w_sl[k] = r_active[8*k + 3];
            w_cs[k] = r_active[8*k + 4];
            w_pd[k] = r_active[8*k + 5];
            w_pu[k] = r_active[8*k + 6];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= {NUM_CH{RST_CFG}};
            r_active <= {NUM_CH{RST_CFG}};
            r_pad_a  <= '0;
            r_pad_oe <= '0;
            r_pad_ie <= {NUM_CH{RST_CFG[2]}};
            r_pad_sl <= {NUM_CH{RST_CFG[3]}};
            r_pad_cs <= {NUM_CH{RST_CFG[4]}};
            r_pad_pd <= {NUM_CH{RST_CFG[5]}};
            r_pad_pu <= {NUM_CH{RST_CFG[6]}};
        end else begin
            if (cfg_shift) r_shadow <= {r_shadow[W-2:0], cfg_sdi};
            // Load copies the pre-edge shadow, so a simultaneous shift does not leak into active.
            if (cfg_load)  r_active <= r_shadow;
            r_pad_a  <= w_a;
            r_pad_oe <= w_oe;
            r_pad_ie <= w_ie;
            r_pad_sl <= w_sl;
            r_pad_cs <= w_cs;
            r_pad_pd <= w_pd;
            r_pad_pu <= w_pu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_din <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else begin
            r_s1 <= pad_Y;
            r_s2 <= r_s1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (!r_active[8*k + 7]) begin
                    r_din[k] <= r_s2[k];
                    r_cnt[k] <= '0;
                end else if (r_s2[k] == r_din[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_MAX) begin
                    r_din[k] <= r_s2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
                // Counter clear on load takes priority over the per-channel update above.
                if (cfg_load) r_cnt[k] <= '0;
            end
        end
    end

    assign cfg_sdo = r_shadow[W-1];
    assign din     = r_din;
    assign pad_A   = r_pad_a;
    assign pad_OE  = r_pad_oe;
    assign pad_IE  = r_pad_ie;
    assign pad_SL  = r_pad_sl;
    assign pad_CS  = r_pad_cs;
    assign pad_PD  = r_pad_pd;
    assign pad_PU  = r_pad_pu;

endmodule
